// File: rtl/fb_pixel_writer.sv
// Framebuffer sink for the rasterizer pixel stream: decodes fixed-point screen
// coordinates to linear addresses, queues writes and reports per-tile completion.
module fb_pixel_writer #(
  parameter int FX_TOTAL_BITS     = 32,
  parameter int FX_FRAC_BITS      = 16,
  parameter int COLOR_BITS        = 8,
  parameter int TILE_WIDTH        = 16,
  parameter int TILE_COLUMNS_BITS = 6,
  parameter int TILE_ROWS_BITS    = 5,
  parameter int FB_ADDR_BITS      = 2 * $clog2(TILE_WIDTH) + TILE_COLUMNS_BITS + TILE_ROWS_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [COLOR_BITS-1:0]        in_color,
  input  logic [FX_TOTAL_BITS-1:0]     in_pixel_x,
  input  logic [FX_TOTAL_BITS-1:0]     in_pixel_y,
  output logic                         fb_write_en,
  output logic [FB_ADDR_BITS-1:0]      fb_write_addr,
  output logic [COLOR_BITS-1:0]        fb_write_data,
  input  logic                         fb_rdy,
  output logic                         tile_done,
  output logic [TILE_COLUMNS_BITS-1:0] tile_done_x,
  output logic [TILE_ROWS_BITS-1:0]    tile_done_y,
  output logic                         err_oob
);

  localparam int TW_BITS  = $clog2(TILE_WIDTH);
  localparam int X_BITS   = TW_BITS + TILE_COLUMNS_BITS;
  localparam int Y_BITS   = TW_BITS + TILE_ROWS_BITS;
  localparam int CNT_BITS = 2 * TW_BITS;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  typedef struct packed {
    logic                    wr;
    logic                    last;
    logic [FB_ADDR_BITS-1:0] addr;
    logic [COLOR_BITS-1:0]   color;
  } entry_t;

  state_t                           state;
  logic                             run_q;
  entry_t                           head;
  entry_t                           tail;
  logic [1:0]                       count;
  logic [CNT_BITS-1:0]              pix_cnt;

  logic signed [FX_TOTAL_BITS-1:0]  xi;
  logic signed [FX_TOTAL_BITS-1:0]  yi;
  logic                             in_range;
  logic                             is_last;
  logic                             pop;
  logic                             accept;
  logic                             push;
  entry_t                           new_entry;

  always_comb begin
    xi        = $signed(in_pixel_x) >>> FX_FRAC_BITS;
    yi        = $signed(in_pixel_y) >>> FX_FRAC_BITS;
    // Upper bits all zero covers both the sign check and the screen bound.
    in_range  = (xi[FX_TOTAL_BITS-1:X_BITS] == '0) && (yi[FX_TOTAL_BITS-1:Y_BITS] == '0);
    is_last   = (pix_cnt == '1);
    new_entry = '{wr: in_range, last: is_last,
                  addr: {yi[Y_BITS-1:0], xi[X_BITS-1:0]}, color: in_color};
  end

  // A marker entry (wr=0) retires as soon as it reaches the head.
  assign pop    = (count != 2'd0) && (!head.wr || fb_rdy);
  assign in_rdy = run_q && (state != DONE) && ((count != 2'd2) || pop);
  assign accept = in_vld && in_rdy;
  assign push   = accept && (in_range || is_last);

  assign fb_write_en   = (count != 2'd0) && head.wr;
  assign fb_write_addr = head.addr;
  assign fb_write_data = head.color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (pop && push) begin
      if (count == 2'd2) begin
        head <= tail;
        tail <= new_entry;
      end else begin
        head <= new_entry;
      end
    end else if (pop) begin
      head  <= tail;
      count <= count - 2'd1;
    end else if (push) begin
      if (count == 2'd0) head <= new_entry;
      else               tail <= new_entry;
      count <= count + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_q       <= 1'b0;
      pix_cnt     <= '0;
      tile_done   <= 1'b0;
      tile_done_x <= '0;
      tile_done_y <= '0;
      err_oob     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      tile_done <= 1'b0;
      if (accept && !in_range) err_oob <= 1'b1;
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (is_last) begin
              state       <= DONE;
              tile_done_x <= xi[TW_BITS +: TILE_COLUMNS_BITS];
              tile_done_y <= yi[TW_BITS +: TILE_ROWS_BITS];
            end else begin
              state <= STREAM;
            end
          end
        end
        DONE: begin
          if (pop && head.last) begin
            tile_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
